mem_load_ext: RTL and testbench

Parametrised load-data aligner and extender for the memory stage of the MIPS pipeline. It is the next generation of the 16-bit immediate extender, generalised in data width, access size and endianness. It takes a raw memory word, selects the addressed byte, half, word or dword lane, and sign- or zero-extends it to the full datapath width. It registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a writeback stall never combinationally reaches the memory side.

---
 rtl/mem_ext_pkg.sv | 15 +
 rtl/lane_ext.sv | 78 +++++++
 rtl/mem_load_ext.sv | 113 +++++++++++
 tb/tb_mem_load_ext.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ext_pkg.sv
// Shared definitions for the memory-stage load aligner/extender.
//   size_e      : access-size encoding carried on in_size (byte..dword)
//   SKID_DEPTH  : number of result entries held behind the output handshake
package mem_ext_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/lane_ext.sv
// Combinational lane selector and extender.
// Picks the byte/half/word/dword lane addressed by ofs out of a raw memory
// word, sign- or zero-extends it to DATA_W, and flags bad sizes and
// misaligned offsets (flagged accesses produce zero data).
//   data     : raw memory word
//   ofs      : byte offset within the word
//   size     : access size, log2 of the byte count
//   sext     : 1 = sign-extend, 0 = zero-extend
//   ext      : aligned, extended result
//   misalign : ofs is not a multiple of the access size
//   badsize  : access is wider than DATA_W (wins over misalign)
module lane_ext
    import mem_ext_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int BIG_END = 0,
    localparam int OFS_W   = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [1:0]        size,
    input  logic              sext,
    output logic [DATA_W-1:0] ext,
    output logic              misalign,
    output logic              badsize
);

    // Wide enough to hold DATA_W itself as a bit count.
    localparam int SH_W = $clog2(DATA_W) + 1;

    logic [SH_W-1:0]   lane_bits;
    logic [SH_W-1:0]   ofs_bits;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] top_mask;
    logic [DATA_W-1:0] lane;
    logic [OFS_W-1:0]  ofs_mask;
    logic              fill;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave a value held and infer a latch.
        ext      = '0;
        misalign = 1'b0;

        // An access of 2^size bytes fits only if size <= log2(DATA_W/8).
        badsize  = int'(size) > OFS_W;

        lane_bits = SH_W'(8) << size;
        ofs_bits  = SH_W'({ofs, 3'b000});

        // Big-endian lane 0 starts at the MSB end of the word. The shift can
        // only underflow for flagged accesses, whose data is discarded.
        if (BIG_END != 0)
            shamt = SH_W'(DATA_W) - ofs_bits - lane_bits;
        else
            shamt = ofs_bits;

        shifted = data >> shamt;

        // Shifting by the full width yields zero, so a full-width lane gets an
        // all-ones mask and the fill below becomes a no-op.
        lane_mask = ~({DATA_W{1'b1}} << lane_bits);
        top_mask  = lane_mask ^ (lane_mask >> 1);
        lane      = shifted & lane_mask;
        fill      = sext & (|(lane & top_mask));

        ofs_mask = ~({OFS_W{1'b1}} << size);

        if (!badsize) begin
            misalign = |(ofs & ofs_mask);
            if (!misalign)
                ext = fill ? (lane | ~lane_mask) : lane;
        end
    end

endmodule

// File: rtl/mem_load_ext.sv
// Memory-stage load aligner/extender with a registered 2-entry skid buffer.
// Each accepted request is run through lane_ext and queued together with its
// tag and status flags; the head entry drives the outputs directly from
// flops, so out_ready never reaches in_ready combinationally.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/ready: request handshake (in_ready from buffer occupancy only)
//   in_data       : raw memory word
//   in_ofs        : byte offset within the word
//   in_size       : access size (0 byte, 1 half, 2 word, 3 dword)
//   in_sext       : 1 = sign-extend, 0 = zero-extend
//   in_tag        : pass-through tag (destination register)
//   out_valid/ready: result handshake
//   out_data      : aligned, extended result of the head entry
//   out_tag       : tag of the head entry
//   out_misalign  : head entry was misaligned
//   out_badsize   : head entry asked for a size wider than DATA_W
module mem_load_ext
    import mem_ext_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int TAG_W   = 5,
    parameter  int BIG_END = 0,
    localparam int OFS_W   = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFS_W-1:0]  in_ofs,
    input  logic [1:0]        in_size,
    input  logic              in_sext,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign,
    output logic              out_badsize
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              misalign;
        logic              badsize;
    } entry_t;

    entry_t     new_entry;
    entry_t     head;   // slot 0: drives the outputs
    entry_t     tail;   // slot 1: only occupied when count == 2
    logic [1:0] count;
    logic       push;
    logic       pop;

    lane_ext #(
        .DATA_W  (DATA_W),
        .BIG_END (BIG_END)
    ) u_lane_ext (
        .data     (in_data),
        .ofs      (in_ofs),
        .size     (in_size),
        .sext     (in_sext),
        .ext      (new_entry.data),
        .misalign (new_entry.misalign),
        .badsize  (new_entry.badsize)
    );

    assign new_entry.tag = in_tag;

    assign in_ready = !rst && (count < 2'(SKID_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: state is written with <= only, so every register samples the
        // pre-edge values and head/tail can shift in the same edge safely.
        if (rst) begin
            count <= '0;
            // NOTE: both slots are cleared, not just the count, because the
            // outputs read the head slot directly and must be zero after reset.
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        head <= new_entry;
                    else
                        tail <= new_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count == 1: the head leaves and the
                    // newcomer takes its place, so order is preserved.
                    head <= new_entry;
                end
                default: ;
            endcase
        end
    end

    assign out_valid    = (count != 2'd0);
    assign out_data     = head.data;
    assign out_tag      = head.tag;
    assign out_misalign = head.misalign;
    assign out_badsize  = head.badsize;

endmodule

// File: tb/tb_mem_load_ext.sv
// Bench for mem_load_ext: three instances (32-bit little-endian, 32-bit
// big-endian, 64-bit little-endian) share one input stream. Directed vectors,
// hand-written backpressure/reset sequences, then randomized traffic checked
// against a queue-based reference model.
module tb_mem_load_ext;
    import mem_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] data;
    logic [2:0]  ofs;
    logic [1:0]  size;
    logic        sext;
    logic [4:0]  tag;

    logic        a_ready, b_ready, c_ready;
    logic        a_valid, b_valid, c_valid;
    logic [31:0] a_data, b_data;
    logic [63:0] c_data;
    logic [4:0]  a_tag, b_tag, c_tag;
    logic        a_mis, b_mis, c_mis;
    logic        a_bad, b_bad, c_bad;

    logic        o_ready [3];
    logic        o_valid [3];
    logic [63:0] o_data  [3];
    logic [4:0]  o_tag   [3];
    logic        o_mis   [3];
    logic        o_bad   [3];

    int    cfg_dw   [3] = '{32, 32, 64};
    bit    cfg_be   [3] = '{1'b0, 1'b1, 1'b0};
    string cfg_name [3] = '{"le32", "be32", "le64"};

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_load_ext #(.DATA_W(32), .TAG_W(5), .BIG_END(0)) u_le32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(data[31:0]), .in_ofs(ofs[1:0]), .in_size(size), .in_sext(sext),
        .in_tag(tag), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .out_tag(a_tag), .out_misalign(a_mis), .out_badsize(a_bad)
    );

    mem_load_ext #(.DATA_W(32), .TAG_W(5), .BIG_END(1)) u_be32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .in_data(data[31:0]), .in_ofs(ofs[1:0]), .in_size(size), .in_sext(sext),
        .in_tag(tag), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_tag(b_tag), .out_misalign(b_mis), .out_badsize(b_bad)
    );

    mem_load_ext #(.DATA_W(64), .TAG_W(5), .BIG_END(0)) u_le64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ready),
        .in_data(data), .in_ofs(ofs), .in_size(size), .in_sext(sext),
        .in_tag(tag), .out_valid(c_valid), .out_ready(out_ready),
        .out_data(c_data), .out_tag(c_tag), .out_misalign(c_mis), .out_badsize(c_bad)
    );

    always_comb begin
        o_ready[0] = a_ready; o_ready[1] = b_ready; o_ready[2] = c_ready;
        o_valid[0] = a_valid; o_valid[1] = b_valid; o_valid[2] = c_valid;
        o_data[0]  = {32'd0, a_data};
        o_data[1]  = {32'd0, b_data};
        o_data[2]  = c_data;
        o_tag[0]   = a_tag;   o_tag[1]   = b_tag;   o_tag[2]   = c_tag;
        o_mis[0]   = a_mis;   o_mis[1]   = b_mis;   o_mis[2]   = c_mis;
        o_bad[0]   = a_bad;   o_bad[1]   = b_bad;   o_bad[2]   = c_bad;
    end

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        mis;
        logic        bad;
    } rec_t;

    typedef struct {
        int          cfg;
        logic [63:0] data;
        logic [2:0]  ofs;
        logic [1:0]  size;
        logic        sext;
        logic [63:0] exp_data;
        logic        exp_mis;
        logic        exp_bad;
    } vec_t;

    rec_t q0[$];
    rec_t q1[$];
    rec_t q2[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected result straight from the access rules: byte count, alignment,
    // lane position from either end of the word, then extension by masking.
    function automatic rec_t ref_model(input int k);
        rec_t        r;
        int          dw, nb, sb, ofs_m, sh;
        logic [63:0] dmask, lmask, lane;
        dw    = cfg_dw[k];
        nb    = 1 << size;
        sb    = 8 * nb;
        ofs_m = int'(ofs) % (dw / 8);
        r.tag  = tag;
        r.data = 64'd0;
        r.mis  = 1'b0;
        r.bad  = 1'b0;
        if (sb > dw) begin
            r.bad = 1'b1;
        end else if (ofs_m % nb != 0) begin
            r.mis = 1'b1;
        end else begin
            dmask = (dw == 64) ? {64{1'b1}} : ((64'd1 << dw) - 64'd1);
            lmask = (sb == 64) ? {64{1'b1}} : ((64'd1 << sb) - 64'd1);
            sh    = cfg_be[k] ? (dw - 8 * ofs_m - sb) : (8 * ofs_m);
            lane  = ((data & dmask) >> sh) & lmask;
            if (sext && sb < dw && lane[sb-1])
                lane = lane | (dmask & ~lmask);
            r.data = lane;
        end
        return r;
    endfunction

    task automatic check_state(input int k, input rec_t q[$]);
        string p;
        p = cfg_name[k];
        check({p, " in_ready"}, 64'(o_ready[k]), 64'(!rst && q.size() < 2));
        check({p, " out_valid"}, 64'(o_valid[k]), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check({p, " out_data"}, o_data[k], q[0].data);
            check({p, " out_tag"}, 64'(o_tag[k]), 64'(q[0].tag));
            check({p, " out_misalign"}, 64'(o_mis[k]), 64'(q[0].mis));
            check({p, " out_badsize"}, 64'(o_bad[k]), 64'(q[0].bad));
        end
    endtask

    task automatic step_model(input int k, ref rec_t q[$]);
        bit do_push, do_pop;
        rec_t r;
        do_push = in_valid && q.size() < 2;
        do_pop  = out_ready && q.size() != 0;
        if (rst) begin
            q.delete();
        end else begin
            if (do_pop)
                r = q.pop_front();
            if (do_push)
                q.push_back(ref_model(k));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 64'h8899AABB, 3'd1, SZ_BYTE,  1'b1, 64'hFFFFFFAA, 1'b0, 1'b0};
        vecs[1]  = '{0, 64'h8899AABB, 3'd2, SZ_HALF,  1'b0, 64'h00008899, 1'b0, 1'b0};
        vecs[2]  = '{0, 64'h8899AABB, 3'd1, SZ_HALF,  1'b0, 64'h0,        1'b1, 1'b0};
        vecs[3]  = '{0, 64'h8899AABB, 3'd0, SZ_DWORD, 1'b1, 64'h0,        1'b0, 1'b1};
        vecs[4]  = '{0, 64'h8899AABB, 3'd1, SZ_DWORD, 1'b0, 64'h0,        1'b0, 1'b1};
        vecs[5]  = '{1, 64'h8899AABB, 3'd0, SZ_BYTE,  1'b1, 64'hFFFFFF88, 1'b0, 1'b0};
        vecs[6]  = '{1, 64'h8899AABB, 3'd2, SZ_HALF,  1'b1, 64'hFFFFAABB, 1'b0, 1'b0};
        vecs[7]  = '{0, 64'h8899AABB, 3'd0, SZ_WORD,  1'b1, 64'h8899AABB, 1'b0, 1'b0};
        vecs[8]  = '{0, 64'h8899AABB, 3'd3, SZ_BYTE,  1'b0, 64'h00000088, 1'b0, 1'b0};
        vecs[9]  = '{2, 64'h0123456789ABCDEF, 3'd0, SZ_DWORD, 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0};
        vecs[10] = '{2, 64'h0123456789ABCDEF, 3'd4, SZ_WORD,  1'b1, 64'h0000000001234567, 1'b0, 1'b0};
        vecs[11] = '{2, 64'h0123456789ABCDEF, 3'd4, SZ_DWORD, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[12] = '{2, 64'h8123456789ABCDEF, 3'd6, SZ_HALF,  1'b1, 64'hFFFFFFFFFFFF8123, 1'b0, 1'b0};
        vecs[13] = '{1, 64'h8899AABB, 3'd3, SZ_BYTE,  1'b0, 64'h000000BB, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data = '0; ofs = '0; size = '0; sext = 1'b0; tag = '0;

        // Reset state, sampled while rst is still high.
        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check({cfg_name[k], " rst in_ready"}, 64'(o_ready[k]), 64'd0);
            check({cfg_name[k], " rst out_valid"}, 64'(o_valid[k]), 64'd0);
            check({cfg_name[k], " rst out_data"}, o_data[k], 64'd0);
        end
        rst = 1'b0;
        #1;
        check("le32 in_ready after rst", 64'(o_ready[0]), 64'd1);

        // Directed vectors: one request per cycle, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            data = vecs[i].data; ofs = vecs[i].ofs; size = vecs[i].size;
            sext = vecs[i].sext; tag = 5'(i);
            @(posedge clk); @(negedge clk);
            check($sformatf("vec%0d %s valid", i, cfg_name[vecs[i].cfg]), 64'(o_valid[vecs[i].cfg]), 64'd1);
            check($sformatf("vec%0d %s data", i, cfg_name[vecs[i].cfg]), o_data[vecs[i].cfg], vecs[i].exp_data);
            check($sformatf("vec%0d %s mis", i, cfg_name[vecs[i].cfg]), 64'(o_mis[vecs[i].cfg]), 64'(vecs[i].exp_mis));
            check($sformatf("vec%0d %s bad", i, cfg_name[vecs[i].cfg]), 64'(o_bad[vecs[i].cfg]), 64'(vecs[i].exp_bad));
            check($sformatf("vec%0d %s tag", i, cfg_name[vecs[i].cfg]), 64'(o_tag[vecs[i].cfg]), 64'(i));
        end
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("drain out_valid", 64'(o_valid[0]), 64'd0);

        // Backpressure: three back-to-back requests against a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1;
        data = 64'h11223344; ofs = 3'd0; size = SZ_WORD; sext = 1'b0; tag = 5'd1;
        @(posedge clk); @(negedge clk);
        check("bp tag1 out_tag", 64'(o_tag[0]), 64'd1);
        check("bp in_ready after 1", 64'(o_ready[0]), 64'd1);
        tag = 5'd2;
        @(posedge clk); @(negedge clk);
        check("bp in_ready full", 64'(o_ready[0]), 64'd0);
        tag = 5'd3;
        @(posedge clk); @(negedge clk);
        check("bp hold in_ready", 64'(o_ready[0]), 64'd0);
        check("bp hold out_tag", 64'(o_tag[0]), 64'd1);
        check("bp hold out_data", o_data[0], 64'h11223344);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp second out_tag", 64'(o_tag[0]), 64'd2);
        check("bp in_ready freed", 64'(o_ready[0]), 64'd1);
        @(posedge clk); @(negedge clk);
        check("bp third out_tag", 64'(o_tag[0]), 64'd3);
        check("bp third valid", 64'(o_valid[0]), 64'd1);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("bp empty valid", 64'(o_valid[0]), 64'd0);

        // Reset with two entries buffered.
        out_ready = 1'b0; in_valid = 1'b1; data = 64'h8899AABB; tag = 5'd7;
        @(posedge clk); @(negedge clk);
        tag = 5'd8;
        @(posedge clk); @(negedge clk);
        check("rst2 full in_ready", 64'(o_ready[0]), 64'd0);
        rst = 1'b1; tag = 5'd9;
        @(posedge clk); @(negedge clk);
        check("rst2 out_valid", 64'(o_valid[0]), 64'd0);
        check("rst2 out_data", o_data[0], 64'd0);
        check("rst2 out_tag", 64'(o_tag[0]), 64'd0);
        check("rst2 in_ready during rst", 64'(o_ready[0]), 64'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("rst2 in_ready after", 64'(o_ready[0]), 64'd1);
        @(posedge clk); @(negedge clk);
        check("rst2 no stale entry", 64'(o_valid[0]), 64'd0);
        in_valid = 1'b1; tag = 5'd10; size = SZ_BYTE; ofs = 3'd0; sext = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst2 fresh tag", 64'(o_tag[0]), 64'd10);
        check("rst2 fresh data", o_data[0], 64'h000000BB);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst2 final empty", 64'(o_valid[0]), 64'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 500; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            data      = {$urandom, $urandom};
            ofs       = 3'($urandom_range(0, 7));
            size      = 2'($urandom_range(0, 3));
            sext      = 1'($urandom_range(0, 1));
            tag       = 5'($urandom_range(0, 31));
            #1;
            check_state(0, q0);
            check_state(1, q1);
            check_state(2, q2);
            step_model(0, q0);
            step_model(1, q1);
            step_model(2, q2);
            @(posedge clk); @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
